// File: rtl/control_botones_pkg.sv
// Shared constants and state encoding for the button run-control stage.
package control_botones_pkg;

    localparam int unsigned CLK_FREQ    = 100_000_000;
    localparam int unsigned TICK_HZ     = 4;
    localparam int unsigned DEBOUNCE_MS = 10;

    // 10 ms debounce window and 4 Hz count tick at the board clock.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DEF_TICK_DIV        = CLK_FREQ / TICK_HZ;
    localparam int unsigned DEF_CNT_W           = 32;

    localparam logic ST_STOPPED = 1'b0;
    localparam logic ST_RUNNING = 1'b1;

    typedef enum logic {
        STOPPED = ST_STOPPED,
        RUNNING = ST_RUNNING
    } state_t;

endpackage

// File: rtl/control_botones_antirrebote.sv
// One push-button: 2-flop synchronizer, debounce filter, registered press pulse.
module antirrebote
    import control_botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the raw level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has persisted for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Single-cycle pulse on the debounced rising edge; release is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/control_botones.sv
// Run/stop, clear and direction control feeding the BCD counter.
module control_botones
    import control_botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_run,
    input  logic btn_clr,
    input  logic btn_dir,
    output logic tick_o,
    output logic clr_o,
    output logic dir_o,
    output logic running_o
);

    logic             w_press_run;
    logic             w_press_clr;
    logic             w_press_dir;
    logic             w_run_go;
    logic             w_clr_go;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_clr;
    logic             w_clr_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_running;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_run),
        .o_press (w_press_run)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clr),
        .o_press (w_press_clr)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_dir (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_dir),
        .o_press (w_press_dir)
    );

    // Run and clear presses are dropped while the block is disabled.
    assign w_run_go = w_press_run & ena;
    assign w_clr_go = w_press_clr & ena;

    // Next state, prescaler and output strobes; clear beats run beats tick.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_tick_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        w_dir_nxt   = r_dir ^ w_press_dir;

        if (w_clr_go) begin
            w_clr_nxt   = 1'b1;
            w_presc_nxt = '0;
            w_state_nxt = STOPPED;
        end else if (w_run_go) begin
            if (r_state == STOPPED) begin
                w_state_nxt = RUNNING;
                w_presc_nxt = '0;
            end else begin
                // Pause: prescaler keeps its count.
                w_state_nxt = STOPPED;
            end
        end else if (ena && (r_state == RUNNING)) begin
            if (r_presc == CNT_W'(TICK_DIV - 1)) begin
                w_presc_nxt = '0;
                w_tick_nxt  = 1'b1;
            end else begin
                w_presc_nxt = r_presc + CNT_W'(1);
            end
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= STOPPED;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_clr     <= 1'b0;
            r_dir     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_tick    <= w_tick_nxt;
            r_clr     <= w_clr_nxt;
            r_dir     <= w_dir_nxt;
            r_running <= (w_state_nxt == RUNNING);
        end
    end

    assign tick_o    = r_tick;
    assign clr_o     = r_clr;
    assign dir_o     = r_dir;
    assign running_o = r_running;

endmodule

// File: tb/tb_control_botones.sv
// Scoreboard bench for control_botones with a short debounce window and tick period.
module tb_control_botones;

    localparam int unsigned DB  = 4;
    localparam int unsigned DIV = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic btn_run;
    logic btn_clr;
    logic btn_dir;
    logic tick_o;
    logic clr_o;
    logic dir_o;
    logic running_o;

    typedef struct {
        int   cyc;
        logic tick;
        logic clr;
        logic run;
        logic dir;
    } ev_t;

    ev_t q[$];
    int  cyc      = 0;
    int  compared = 0;
    int  failed   = 0;
    int  ev_idx   = 0;

    control_botones #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(DIV), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .btn_dir   (btn_dir),
        .tick_o    (tick_o),
        .clr_o     (clr_o),
        .dir_o     (dir_o),
        .running_o (running_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input int c, input logic t, input logic cl,
                                      input logic r, input logic d);
        ev_t e;
        e.cyc = c; e.tick = t; e.clr = cl; e.run = r; e.dir = d;
        q.push_back(e);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s got=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: any strobe or level change is an event matched against the queue.
    initial begin : monitor
        ev_t  e;
        logic prev_run;
        logic prev_dir;
        prev_run = 1'b0;
        prev_dir = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_o === 1'b1 || clr_o === 1'b1 ||
                running_o !== prev_run || dir_o !== prev_dir) begin
                compared++;
                if (q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_event cyc=%0d got t/c/r/d=%b%b%b%b required no event",
                             cyc, tick_o, clr_o, running_o, dir_o);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.tick !== tick_o || e.clr !== clr_o ||
                        e.run !== running_o || e.dir !== dir_o) begin
                        failed++;
                        $display("FAIL event_%0d got cyc=%0d t/c/r/d=%b%b%b%b required cyc=%0d t/c/r/d=%b%b%b%b",
                                 ev_idx, cyc, tick_o, clr_o, running_o, dir_o,
                                 e.cyc, e.tick, e.clr, e.run, e.dir);
                    end
                end
                ev_idx++;
            end
            prev_run = running_o;
            prev_dir = dir_o;
        end
    end

    // Stimulus: each press lands on the outputs DB+3 edges after it is first sampled.
    initial begin : stim
        int c;
        ev_t e;
        rst_n   = 1'b1;
        ena     = 1'b1;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        btn_dir = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tick",    tick_o,    1'b0);
        chk("rst_clr",     clr_o,     1'b0);
        chk("rst_dir",     dir_o,     1'b0);
        chk("rst_running", running_o, 1'b0);
        steps(3);
        rst_n = 1'b1;
        steps(50);
        chk("idle_tick",    tick_o,    1'b0);
        chk("idle_clr",     clr_o,     1'b0);
        chk("idle_dir",     dir_o,     1'b0);
        chk("idle_running", running_o, 1'b0);

        // Start, four ticks, stop.
        c = cyc;
        expect_ev(c + 8,  1'b0, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 13, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 18, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 23, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 28, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 30, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b1;
        steps(10);
        btn_run = 1'b0;
        steps(12);
        btn_run = 1'b1;
        steps(5);
        btn_run = 1'b0;
        steps(20);

        // Three-cycle glitch is filtered out.
        btn_run = 1'b1;
        steps(3);
        btn_run = 1'b0;
        steps(20);

        // Clear while running with the prescaler at 3.
        c = cyc;
        expect_ev(c + 8,  1'b0, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 12, 1'b0, 1'b1, 1'b0, 1'b0);
        btn_run = 1'b1;
        steps(4);
        btn_clr = 1'b1;
        steps(2);
        btn_run = 1'b0;
        steps(4);
        btn_clr = 1'b0;
        steps(10);

        // Restart from zero, then run+clear together on the would-be tick edge.
        c = cyc;
        expect_ev(c + 8,  1'b0, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 13, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(c + 18, 1'b0, 1'b1, 1'b0, 1'b0);
        btn_run = 1'b1;
        steps(5);
        btn_run = 1'b0;
        steps(5);
        btn_run = 1'b1;
        btn_clr = 1'b1;
        steps(6);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        steps(20);

        // Direction toggles twice.
        c = cyc;
        expect_ev(c + 8,  1'b0, 1'b0, 1'b0, 1'b1);
        expect_ev(c + 28, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_dir = 1'b1;
        steps(6);
        btn_dir = 1'b0;
        steps(14);
        btn_dir = 1'b1;
        steps(6);
        btn_dir = 1'b0;
        steps(20);

        // Disabled: run press dropped, direction still toggles.
        c = cyc;
        expect_ev(c + 8, 1'b0, 1'b0, 1'b0, 1'b1);
        ena     = 1'b0;
        btn_run = 1'b1;
        btn_dir = 1'b1;
        steps(6);
        btn_run = 1'b0;
        btn_dir = 1'b0;
        steps(14);
        ena = 1'b1;
        steps(10);

        // Asynchronous reset in the middle of a count.
        c = cyc;
        expect_ev(c + 8,  1'b0, 1'b0, 1'b1, 1'b1);
        expect_ev(c + 11, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b1;
        steps(6);
        btn_run = 1'b0;
        steps(4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tick",    tick_o,    1'b0);
        chk("async_rst_clr",     clr_o,     1'b0);
        chk("async_rst_dir",     dir_o,     1'b0);
        chk("async_rst_running", running_o, 1'b0);
        steps(3);
        rst_n = 1'b1;
        steps(30);

        while (q.size() != 0) begin
            e = q.pop_front();
            compared++;
            failed++;
            $display("FAIL missing_event got none required cyc=%0d t/c/r/d=%b%b%b%b",
                     e.cyc, e.tick, e.clr, e.run, e.dir);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
